// File: rtl/alsu_hs_if.sv
// Operand/result handshake bundle for alsu_hs.
// The master drives operations and consumes results; the slave is the core.
interface alsu_hs_if #(
    parameter int WIDTH = 3,
    parameter int LED_W = 16
);
    localparam int OW = 2 * WIDTH;

    logic                    in_valid;
    logic                    in_ready;
    logic [2:0]              opcode;
    logic signed [WIDTH-1:0] A;
    logic signed [WIDTH-1:0] B;
    logic                    cin;
    logic                    serial_in;
    logic                    direction;
    logic                    red_op_A;
    logic                    red_op_B;
    logic                    bypass_A;
    logic                    bypass_B;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OW-1:0]    out;
    logic                    err;
    logic [LED_W-1:0]        leds;

    modport master (
        output in_valid, opcode, A, B, cin, serial_in, direction,
               red_op_A, red_op_B, bypass_A, bypass_B, out_ready,
        input  in_ready, out_valid, out, err, leds
    );

    modport slave (
        input  in_valid, opcode, A, B, cin, serial_in, direction,
               red_op_A, red_op_B, bypass_A, bypass_B, out_ready,
        output in_ready, out_valid, out, err, leds
    );
endinterface

// File: rtl/alsu_hs.sv
// Parametrised ALSU with valid/ready handshake, iterative signed multiplier,
// result back-pressure and a blinking error indication.
module alsu_hs #(
    parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    LED_W          = 16
) (
    input  logic     clk,
    input  logic     rst,
    alsu_hs_if.slave bus
);
    localparam int               OW       = 2 * WIDTH;
    localparam int               CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam bit               PRIO_B   = (INPUT_PRIORITY == "B");
    localparam bit               ADD_CIN  = (FULL_ADDER == "ON");
    localparam logic [OW-1:0]    ONE_OW   = OW'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [OW-1:0]    out_q;
    logic             err_q;
    logic [LED_W-1:0] leds_q;
    logic [OW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [OW-1:0]    acc_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q;

    logic             accept_s, invalid_s, bypass_s, red_s;
    logic             pick_b_red_s, pick_b_byp_s, go_mul_s, err_s;
    logic [WIDTH-1:0] a_u_s, b_u_s, red_x_s, b_mag_s;
    logic [OW-1:0]    a_ext_s, b_ext_s, a_mag_s, res_s, acc_d, prod_s;

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out       = out_q;
    assign bus.err       = err_q;
    assign bus.leds      = leds_q;

    // Result of a single-cycle operation and multiplier set-up/step values.
    always_comb begin
        a_u_s        = bus.A;
        b_u_s        = bus.B;
        a_ext_s      = {{WIDTH{a_u_s[WIDTH-1]}}, a_u_s};
        b_ext_s      = {{WIDTH{b_u_s[WIDTH-1]}}, b_u_s};
        accept_s     = bus.in_valid && (state_q == S_IDLE);
        red_s        = bus.red_op_A || bus.red_op_B;
        bypass_s     = bus.bypass_A || bus.bypass_B;
        pick_b_red_s = bus.red_op_B && (!bus.red_op_A || PRIO_B);
        pick_b_byp_s = bus.bypass_B && (!bus.bypass_A || PRIO_B);
        red_x_s      = pick_b_red_s ? b_u_s : a_u_s;
        invalid_s    = (bus.opcode == 3'd6) || (bus.opcode == 3'd7) ||
                       (red_s && (bus.opcode > 3'd1));
        a_mag_s      = a_u_s[WIDTH-1] ? (~a_ext_s + ONE_OW) : a_ext_s;
        b_mag_s      = b_u_s[WIDTH-1] ? (~b_u_s + ONE_W) : b_u_s;
        res_s        = {OW{1'b0}};
        err_s        = 1'b0;
        go_mul_s     = 1'b0;
        if (invalid_s) begin
            err_s = 1'b1;
        end else if (bypass_s) begin
            res_s = pick_b_byp_s ? b_ext_s : a_ext_s;
        end else begin
            case (bus.opcode)
                3'd0: res_s = red_s ? {{(OW-1){1'b0}}, &red_x_s}
                                    : {{WIDTH{1'b0}}, a_u_s & b_u_s};
                3'd1: res_s = red_s ? {{(OW-1){1'b0}}, ^red_x_s}
                                    : {{WIDTH{1'b0}}, a_u_s ^ b_u_s};
                3'd2: res_s = a_ext_s + b_ext_s + {{(OW-1){1'b0}}, bus.cin & ADD_CIN};
                3'd3: begin
                    go_mul_s = 1'b1;
                    res_s    = out_q;
                end
                3'd4: res_s = bus.direction ? {out_q[OW-2:0], bus.serial_in}
                                            : {bus.serial_in, out_q[OW-1:1]};
                3'd5: res_s = bus.direction ? {out_q[OW-2:0], out_q[OW-1]}
                                            : {out_q[0], out_q[OW-1:1]};
                default: err_s = 1'b1;
            endcase
        end
        // One partial product per cycle; the sign is applied on the last step.
        acc_d  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        prod_s = neg_q ? (~acc_d + ONE_OW) : acc_d;
    end

    // Control FSM with registered result, error and led outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            out_q    <= {OW{1'b0}};
            err_q    <= 1'b0;
            leds_q   <= {LED_W{1'b0}};
            mcand_q  <= {OW{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {OW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            neg_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    leds_q <= {LED_W{1'b0}};
                    if (accept_s) begin
                        if (go_mul_s) begin
                            mcand_q  <= a_mag_s;
                            mplier_q <= b_mag_s;
                            acc_q    <= {OW{1'b0}};
                            cnt_q    <= {CW{1'b0}};
                            neg_q    <= a_u_s[WIDTH-1] ^ b_u_s[WIDTH-1];
                            state_q  <= S_MUL;
                        end else begin
                            out_q   <= res_s;
                            err_q   <= err_s;
                            leds_q  <= err_s ? {LED_W{1'b1}} : {LED_W{1'b0}};
                            state_q <= S_DONE;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_MUL: begin
                    leds_q <= {LED_W{1'b0}};
                    if (cnt_q == CNT_LAST) begin
                        out_q   <= prod_s;
                        err_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        acc_q    <= acc_d;
                        mcand_q  <= {mcand_q[OW-2:0], 1'b0};
                        mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
                        cnt_q    <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        leds_q  <= {LED_W{1'b0}};
                        state_q <= S_IDLE;
                    end else if (err_q) begin
                        leds_q <= ~leds_q;
                    end else begin
                        leds_q <= {LED_W{1'b0}};
                    end
                end
                default: begin
                    leds_q  <= {LED_W{1'b0}};
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alsu_hs.sv
// Randomised and directed bench for alsu_hs (WIDTH=3) against an arithmetic reference model.
module tb_alsu_hs;
    localparam int WIDTH = 3;
    localparam int OW    = 6;
    localparam int LED_W = 16;
    localparam int HALF  = 32;
    localparam int WMASK = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    int            tests_run = 0;
    int            tests_failed = 0;
    logic [OW-1:0] prev_q = 6'd0;

    alsu_hs_if #(.WIDTH(WIDTH), .LED_W(LED_W)) bus ();
    alsu_hs_if #(.WIDTH(WIDTH), .LED_W(LED_W)) bus_b ();

    alsu_hs #(.WIDTH(WIDTH), .INPUT_PRIORITY("A"), .FULL_ADDER("ON"), .LED_W(LED_W))
        dut (.clk(clk), .rst(rst), .bus(bus));
    alsu_hs #(.WIDTH(WIDTH), .INPUT_PRIORITY("B"), .FULL_ADDER("ON"), .LED_W(LED_W))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    // Reference: returns {err, out} from the operation rules and the previous result.
    function automatic logic [OW:0] model(input logic [2:0] op, input int a, input int b,
                                          input bit cin, input bit sin, input bit dir,
                                          input bit ra, input bit rb, input bit ba, input bit bb,
                                          input bit prio_b, input logic [OW-1:0] prev);
        int r;
        int x;
        int p;
        p = int'(prev);
        if (op >= 3'd6 || ((ra || rb) && op > 3'd1)) return {1'b1, 6'd0};
        if (ba || bb) begin
            r = (bb && (!ba || prio_b)) ? b : a;
        end else begin
            x = (rb && (!ra || prio_b)) ? b : a;
            case (op)
                3'd0: r = (ra || rb) ? ((x == -1) ? 1 : 0) : ((a & b) & WMASK);
                3'd1: r = (ra || rb) ? ($countones(x & WMASK) % 2) : ((a ^ b) & WMASK);
                3'd2: r = a + b + (cin ? 1 : 0);
                3'd3: r = a * b;
                3'd4: r = dir ? (p * 2 + (sin ? 1 : 0)) : (p / 2 + (sin ? HALF : 0));
                3'd5: r = dir ? (p * 2 + p / HALF) : (p / 2 + (p % 2) * HALF);
                default: r = 0;
            endcase
        end
        return {1'b0, r[OW-1:0]};
    endfunction

    task automatic drive_idle();
        bus.in_valid = 1'b0; bus.opcode = 3'd0; bus.A = 3'd0; bus.B = 3'd0;
        bus.cin = 1'b0; bus.serial_in = 1'b0; bus.direction = 1'b0;
        bus.red_op_A = 1'b0; bus.red_op_B = 1'b0; bus.bypass_A = 1'b0; bus.bypass_B = 1'b0;
        bus.out_ready = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.opcode = 3'd0; bus_b.A = 3'd0; bus_b.B = 3'd0;
        bus_b.cin = 1'b0; bus_b.serial_in = 1'b0; bus_b.direction = 1'b0;
        bus_b.red_op_A = 1'b0; bus_b.red_op_B = 1'b0; bus_b.bypass_A = 1'b0; bus_b.bypass_B = 1'b0;
        bus_b.out_ready = 1'b0;
    endtask

    // Called at a negedge; returns at the first negedge with out_valid (lat=-1 on timeout).
    task automatic issue(input logic [2:0] op, input int a, input int b,
                         input bit cin, input bit sin, input bit dir,
                         input bit ra, input bit rb, input bit ba, input bit bb,
                         output int lat, output logic [OW-1:0] o, output logic e,
                         output int rdy_hi);
        int n;
        lat = -1; o = 6'd0; e = 1'b0; rdy_hi = 0; n = 0;
        bus.opcode = op; bus.A = a[WIDTH-1:0]; bus.B = b[WIDTH-1:0];
        bus.cin = cin; bus.serial_in = sin; bus.direction = dir;
        bus.red_op_A = ra; bus.red_op_B = rb; bus.bypass_A = ba; bus.bypass_B = bb;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.in_ready) begin bus.in_valid = 1'b0; return; end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 40) begin
            if (bus.in_ready) rdy_hi++;
            @(negedge clk);
            n++;
        end
        if (bus.in_ready) rdy_hi++;
        if (bus.out_valid) begin lat = n; o = bus.out; e = bus.err; end
    endtask

    task automatic release_out();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        tests_run++; if (bus.in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        tests_run++; if (bus.out !== 6'd0) begin tests_failed++; $display("FAIL reset_out: got %b want 000000", bus.out); end
        tests_run++; if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", bus.err); end
        tests_run++; if (bus.leds !== 16'h0000) begin tests_failed++; $display("FAIL reset_leds: got %h want 0000", bus.leds); end
        prev_q = 6'd0;
    endtask

    task automatic test_add();
        int lat, rdy; logic [OW-1:0] o; logic e;
        issue(3'd2, 3, -2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, o, e, rdy);
        tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL add_latency: got %0d want 1", lat); end
        tests_run++; if (o !== 6'd2) begin tests_failed++; $display("FAIL add_out: got %b want 000010", o); end
        tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL add_err: got %b want 0", e); end
        prev_q = 6'd2;
        release_out();
    endtask

    task automatic test_mult();
        int lat, rdy; logic [OW-1:0] o; logic e;
        issue(3'd3, -3, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, o, e, rdy);
        tests_run++; if (lat !== 1 + WIDTH) begin tests_failed++; $display("FAIL mult_latency: got %0d want %0d", lat, 1 + WIDTH); end
        tests_run++; if (o !== 6'b110111) begin tests_failed++; $display("FAIL mult_neg_out: got %b want 110111", o); end
        tests_run++; if (rdy !== 0) begin tests_failed++; $display("FAIL mult_in_ready_busy: got %0d ready cycles want 0", rdy); end
        release_out();
        issue(3'd3, -4, -4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, o, e, rdy);
        tests_run++; if (o !== 6'd16) begin tests_failed++; $display("FAIL mult_min_out: got %b want 010000", o); end
        tests_run++; if (e !== 1'b0) begin tests_failed++; $display("FAIL mult_min_err: got %b want 0", e); end
        prev_q = 6'd16;
        release_out();
    endtask

    task automatic test_invalid_leds();
        int lat, rdy; logic [OW-1:0] o; logic e; logic [LED_W-1:0] want;
        issue(3'd6, 1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, o, e, rdy);
        tests_run++; if (o !== 6'd0 || e !== 1'b1) begin tests_failed++; $display("FAIL invalid_op6: got out=%b err=%b want 000000/1", o, e); end
        for (int k = 0; k < 6; k++) begin
            want = (k % 2 == 0) ? 16'hFFFF : 16'h0000;
            tests_run++;
            if (bus.leds !== want || bus.out_valid !== 1'b1 || bus.out !== 6'd0) begin
                tests_failed++;
                $display("FAIL invalid_hold_%0d: got leds=%h valid=%b out=%b want %h/1/000000", k, bus.leds, bus.out_valid, bus.out, want);
            end
            if (k < 5) @(negedge clk);
        end
        release_out();
        tests_run++; if (bus.leds !== 16'h0000 || bus.out_valid !== 1'b0) begin tests_failed++; $display("FAIL invalid_release: got leds=%h valid=%b want 0000/0", bus.leds, bus.out_valid); end
        issue(3'd2, 1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, lat, o, e, rdy);
        tests_run++; if (o !== 6'd0 || e !== 1'b1) begin tests_failed++; $display("FAIL invalid_red_add: got out=%b err=%b want 000000/1", o, e); end
        prev_q = 6'd0;
        release_out();
    endtask

    task automatic test_reduction();
        int lat, rdy; logic [OW-1:0] o; logic e;
        issue(3'd0, -1, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, lat, o, e, rdy);
        tests_run++; if (o !== 6'd1 || e !== 1'b0) begin tests_failed++; $display("FAIL red_prio_a: got out=%b err=%b want 000001/0", o, e); end
        prev_q = 6'd1;
        release_out();
        bus_b.opcode = 3'd0; bus_b.A = 3'b111; bus_b.B = 3'b011;
        bus_b.red_op_A = 1'b1; bus_b.red_op_B = 1'b1; bus_b.in_valid = 1'b1;
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        tests_run++;
        if (bus_b.out_valid !== 1'b1 || bus_b.out !== 6'd0 || bus_b.err !== 1'b0) begin
            tests_failed++;
            $display("FAIL red_prio_b: got valid=%b out=%b err=%b want 1/000000/0", bus_b.out_valid, bus_b.out, bus_b.err);
        end
        bus_b.out_ready = 1'b1;
        @(negedge clk);
        bus_b.out_ready = 1'b0;
    endtask

    task automatic test_shift_rotate();
        int lat, rdy; logic [OW-1:0] o; logic e;
        issue(3'd1, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, lat, o, e, rdy);
        tests_run++; if (o !== 6'b000001) begin tests_failed++; $display("FAIL bypass_a: got %b want 000001", o); end
        release_out();
        issue(3'd4, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, lat, o, e, rdy);
        tests_run++; if (o !== 6'b000011) begin tests_failed++; $display("FAIL shift_left: got %b want 000011", o); end
        release_out();
        issue(3'd5, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lat, o, e, rdy);
        tests_run++; if (o !== 6'b100001) begin tests_failed++; $display("FAIL rotate_right: got %b want 100001", o); end
        prev_q = 6'b100001;
        release_out();
    endtask

    task automatic test_random();
        int lat, rdy, a, b, hold, want_lat; logic [OW-1:0] o; logic e;
        logic [2:0] op; bit cin, sin, dir, ra, rb, ba, bb; logic [OW:0] exp;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a = int'($urandom_range(0, 7)) - 4; b = int'($urandom_range(0, 7)) - 4;
            cin = 1'($urandom_range(0, 1)); sin = 1'($urandom_range(0, 1)); dir = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 4) == 0); rb = ($urandom_range(0, 4) == 0);
            ba = ($urandom_range(0, 5) == 0); bb = ($urandom_range(0, 5) == 0);
            exp = model(op, a, b, cin, sin, dir, ra, rb, ba, bb, 1'b0, prev_q);
            want_lat = (op == 3'd3 && !exp[OW] && !(ba || bb)) ? 1 + WIDTH : 1;
            issue(op, a, b, cin, sin, dir, ra, rb, ba, bb, lat, o, e, rdy);
            tests_run++;
            if (lat !== want_lat || o !== exp[OW-1:0] || e !== exp[OW]) begin
                tests_failed++;
                $display("FAIL rand_%0d op=%0d a=%0d b=%0d: got lat=%0d out=%b err=%b want lat=%0d out=%b err=%b",
                         i, op, a, b, lat, o, e, want_lat, exp[OW-1:0], exp[OW]);
            end
            hold = int'($urandom_range(0, 2));
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                tests_run++;
                if (bus.out_valid !== 1'b1 || bus.out !== exp[OW-1:0] || bus.err !== exp[OW]) begin
                    tests_failed++;
                    $display("FAIL rand_hold_%0d: got valid=%b out=%b err=%b want 1/%b/%b", i, bus.out_valid, bus.out, bus.err, exp[OW-1:0], exp[OW]);
                end
            end
            prev_q = exp[OW-1:0];
            release_out();
        end
    endtask

    task automatic test_reset_mid_mult();
        int lat, rdy, seen; logic [OW-1:0] o; logic e;
        issue(3'd0, -1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, lat, o, e, rdy);
        release_out();
        bus.opcode = 3'd3; bus.A = 3'b101; bus.B = 3'b011; bus.bypass_A = 1'b0; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out !== 6'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_mult: got valid=%b ready=%b out=%b want 0/1/000000", bus.out_valid, bus.in_ready, bus.out);
        end
        @(negedge clk);
        rst = 1'b0;
        prev_q = 6'd0;
        seen = 0;
        repeat (6) begin @(negedge clk); if (bus.out_valid) seen++; end
        tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL rst_no_result: got %0d valid cycles want 0", seen); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_mult();
        test_invalid_leds();
        test_reduction();
        test_shift_rotate();
        test_random();
        test_reset_mid_mult();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
